dm_access_ctrl: RTL and testbench

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

---
 rtl/dm_pkg.sv | 34 +++
 rtl/dm_access_ctrl_if.sv | 20 ++
 rtl/dm_load_ext.sv | 27 ++
 rtl/dm_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and default address map for the data-memory access controller.
package dm_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_LB  = 4'd0;
    localparam op_t OP_LBU = 4'd1;
    localparam op_t OP_LH  = 4'd2;
    localparam op_t OP_LHU = 4'd3;
    localparam op_t OP_LW  = 4'd4;
    localparam op_t OP_SB  = 4'd5;
    localparam op_t OP_SH  = 4'd6;
    localparam op_t OP_SW  = 4'd7;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] DEF_DM_BYTES = 32'h0000_3000;
    localparam int DEF_N_DEV = 3;
    localparam logic [DEF_N_DEV*32-1:0] DEF_DEV_BASE = {32'h0000_7f20, 32'h0000_7f10, 32'h0000_7f00};
    localparam logic [DEF_N_DEV*32-1:0] DEF_DEV_LAST = {32'h0000_7f23, 32'h0000_7f1b, 32'h0000_7f0b};

    // Request captured when the controller enters WAIT.
    typedef struct packed {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic is_store(op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Memory bus between the access controller (master) and memory/devices (slave).
interface dm_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dm_load_ext.sv
// Selects the addressed byte/half of a bus read word and sign- or zero-extends it.
module dm_load_ext
    import dm_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0, half_sel};
            OP_LW:   data = rdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store access controller: legality check, single-outstanding bus access, load extension.
// Optional bus timeout abort enabled by defining DM_ACCESS_TIMEOUT_EN.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter logic [31:0]          DM_BYTES    = DEF_DM_BYTES,
    parameter int                   N_DEV       = DEF_N_DEV,
    parameter logic [N_DEV*32-1:0]  DEV_BASE    = DEF_DEV_BASE,
    parameter logic [N_DEV*32-1:0]  DEV_LAST    = DEF_DEV_LAST,
    parameter int                   TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  op_t                in_op,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_wdata,
    input  logic               flush,
    dm_access_ctrl_if.master   bus,
    output logic               stall,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               exc_valid,
    output logic [4:0]         exc_code
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    logic [0:0]  state;
    req_t        req_q;
    logic        waiting;
    logic        in_dm, in_dev, cnt_hit, known, legal;
    logic        start, illegal, done, tmo;
    logic [31:0] cnt_word;
    logic [31:0] ext_data;

    function automatic logic [3:0] lane_en(op_t op, logic [1:0] a);
        case (op)
            OP_SB:   lane_en = 4'b0001 << a;
            OP_SH:   lane_en = a[1] ? 4'b1100 : 4'b0011;
            OP_SW:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(op_t op, logic [31:0] d);
        case (op)
            OP_SB:   lane_data = {4{d[7:0]}};
            OP_SH:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    assign waiting = (state == S_WAIT);

    // The count register sits at base+8 of each window and is read-only.
    always_comb begin
        in_dev   = 1'b0;
        cnt_hit  = 1'b0;
        cnt_word = 32'h0;
        for (int i = 0; i < N_DEV; i++) begin
            cnt_word = DEV_BASE[i*32 +: 32] + 32'd8;
            if (in_addr >= DEV_BASE[i*32 +: 32] && in_addr <= DEV_LAST[i*32 +: 32])
                in_dev = 1'b1;
            if (in_addr[31:2] == cnt_word[31:2])
                cnt_hit = 1'b1;
        end
    end

    assign in_dm = (in_addr < DM_BYTES);
    assign known = (in_op <= OP_SW);

    always_comb begin
        case (in_op)
            OP_LB, OP_LBU, OP_SB: legal = in_dm;
            OP_LH, OP_LHU, OP_SH: legal = in_dm && !in_addr[0];
            OP_LW:                legal = (in_addr[1:0] == 2'b00) && (in_dm || in_dev);
            OP_SW:                legal = (in_addr[1:0] == 2'b00) && (in_dm || in_dev) && !cnt_hit;
            default:              legal = 1'b0;
        endcase
    end

    assign start   = !waiting && in_valid && !flush && legal;
    assign illegal = !waiting && in_valid && !flush && known && !legal;
    assign done    = waiting && bus.bus_ack && !flush;

`ifdef DM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (start)
            wait_cnt <= '0;
        else if (waiting)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // An ack arriving in the last allowed cycle still completes normally.
    assign tmo = waiting && !bus.bus_ack && !flush && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            req_q <= '0;
        end else if (start) begin
            state <= S_WAIT;
            req_q <= '{op: in_op, addr: in_addr, wdata: in_wdata};
        end else if (waiting && (flush || bus.bus_ack || tmo)) begin
            state <= S_IDLE;
        end
    end

    dm_load_ext u_load_ext (
        .op    (req_q.op),
        .addr  (req_q.addr[1:0]),
        .rdata (bus.bus_rdata),
        .data  (ext_data)
    );

    assign bus.bus_req    = waiting;
    assign bus.bus_we     = waiting && is_store(req_q.op);
    assign bus.bus_addr   = {req_q.addr[31:2], 2'b00};
    assign bus.bus_byteen = waiting ? lane_en(req_q.op, req_q.addr[1:0]) : 4'b0000;
    assign bus.bus_wdata  = lane_data(req_q.op, req_q.wdata);

    assign stall     = waiting && !done && !tmo;
    assign rsp_valid = done;
    assign rsp_rdata = done ? ext_data : 32'h0;
    assign exc_valid = illegal || tmo;

    always_comb begin
        if (illegal)
            exc_code = is_store(in_op) ? EXC_ADES : EXC_ADEL;
        else if (tmo)
            exc_code = is_store(req_q.op) ? EXC_ADES : EXC_ADEL;
        else
            exc_code = 5'd0;
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: responses and exceptions are checked against a queue of expectations.
module tb_dm_access_ctrl;
    import dm_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    op_t         in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;

    dm_access_ctrl_if bus_if ();

    dm_access_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .flush     (flush),
        .bus       (bus_if),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .exc_valid (exc_valid),
        .exc_code  (exc_code)
    );

    typedef struct {
        bit          is_exc;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model, written from the address map directly.
    function automatic bit m_store(op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit m_legal(op_t op, logic [31:0] a);
        bit dm, dev, cnt;
        dm  = a < 32'h3000;
        dev = (a >= 32'h7f00 && a <= 32'h7f0b) || (a >= 32'h7f10 && a <= 32'h7f1b) ||
              (a >= 32'h7f20 && a <= 32'h7f23);
        cnt = (a == 32'h7f08) || (a == 32'h7f18);
        case (op)
            OP_LB, OP_LBU, OP_SB: return dm;
            OP_LH, OP_LHU, OP_SH: return dm && (a[0] == 1'b0);
            OP_LW:                return (a[1:0] == 2'b00) && (dm || dev);
            OP_SW:                return (a[1:0] == 2'b00) && (dm || dev) && !cnt;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(op_t op, logic [31:0] a, logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a[1:0]);
        case (op)
            OP_LB:   return {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  return {24'h0, sh[7:0]};
            OP_LH:   return {{16{sh[15]}}, sh[15:0]};
            OP_LHU:  return {16'h0, sh[15:0]};
            OP_LW:   return rd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] m_byteen(op_t op, logic [31:0] a);
        case (op)
            OP_SB:   return 4'(1 << a[1:0]);
            OP_SH:   return (a[1] == 1'b1) ? 4'b1100 : 4'b0011;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(op_t op, logic [31:0] d);
        case (op)
            OP_SB:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            OP_SH:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && (rsp_valid || exc_valid)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {30'h0, exc_valid, rsp_valid}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_kind", {31'h0, exc_valid}, {31'h0, e.is_exc});
                if (e.is_exc) chk("sb_exc_code", {27'h0, exc_code}, e.val);
                else          chk("sb_rsp_rdata", rsp_rdata, e.val);
            end
        end
    end

    // One upstream access; lat = WAIT cycles before the ack cycle.
    task automatic access(input op_t op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int lat);
        bit   ok;
        int   nst;
        exp_t e;
        ok = m_legal(op, a);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd;
        e.is_exc = !ok;
        if (ok) e.val = m_store(op) ? 32'h0 : m_load(op, a, rd);
        else    e.val = m_store(op) ? 32'd5 : 32'd4;
        sb_q.push_back(e);
        @(negedge clk);
        chk("issue_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("issue_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        if (!ok) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("illegal_no_req", {31'h0, bus_if.bus_req}, 32'h0);
            return;
        end
        in_op = OP_SH; in_addr = 32'h1; in_wdata = ~wd;
        nst = 0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            nst += int'(stall);
            @(posedge clk); #1;
        end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rd;
        @(negedge clk);
        chk("ack_bus_req", {31'h0, bus_if.bus_req}, 32'h1);
        chk("ack_bus_we", {31'h0, bus_if.bus_we}, {31'h0, m_store(op)});
        chk("ack_bus_addr", bus_if.bus_addr, {a[31:2], 2'b00});
        chk("ack_byteen", {28'h0, bus_if.bus_byteen}, {28'h0, m_byteen(op, a)});
        if (m_store(op)) chk("ack_wdata", bus_if.bus_wdata, m_wdata(op, wd));
        chk("ack_stall", {31'h0, stall}, 32'h0);
        chk("ack_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("stall_cycles", nst, lat);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom; in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; in_valid = 1'b0; in_op = OP_LB; in_addr = '0; in_wdata = '0; flush = 1'b0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("rst_byteen", {28'h0, bus_if.bus_byteen}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_exc_valid", {31'h0, exc_valid}, 32'h0);
        chk("rst_exc_code", {27'h0, exc_code}, 32'h0);
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);

        access(OP_LW,  32'h0000_2ffc, 32'h0, 32'h1234_5678, 3);
        access(OP_LB,  32'h0000_0003, 32'h0, 32'h80AA_BBCC, 0);
        access(OP_LBU, 32'h0000_0003, 32'h0, 32'h80AA_BBCC, 1);
        access(OP_LB,  32'h0000_0001, 32'h0, 32'h1122_7F44, 0);
        access(OP_LH,  32'h0000_0002, 32'h0, 32'h8001_1234, 2);
        access(OP_LHU, 32'h0000_0002, 32'h0, 32'h8001_1234, 0);
        access(OP_LH,  32'h0000_0000, 32'h0, 32'h0000_F00D, 1);
        access(OP_SB,  32'h0000_0005, 32'h1234_56A5, 32'h0, 1);
        access(OP_SH,  32'h0000_0006, 32'h1234_BEEF, 32'h0, 0);
        access(OP_SW,  32'h0000_7f04, 32'hCAFE_F00D, 32'h0, 2);
        access(OP_SW,  32'h0000_7f20, 32'h0BAD_CAFE, 32'h0, 0);
        access(OP_LW,  32'h0000_7f08, 32'h0, 32'h0000_002A, 0);

        access(OP_SH,  32'h0000_0001, 32'h0, 32'h0, 0);
        access(OP_LW,  32'h0000_7f0c, 32'h0, 32'h0, 0);
        access(OP_SW,  32'h0000_7f08, 32'h0, 32'h0, 0);
        access(OP_SW,  32'h0000_7f18, 32'h0, 32'h0, 0);
        access(OP_LW,  32'h0000_3000, 32'h0, 32'h0, 0);
        access(OP_LH,  32'h0000_7f00, 32'h0, 32'h0, 0);
        access(OP_LW,  32'h0000_2ffe, 32'h0, 32'h0, 0);
        access(OP_SB,  32'h0000_3000, 32'h0, 32'h0, 0);

        // Flush in WAIT together with ack: no response, back to IDLE.
        @(posedge clk); #1; in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h40;
        @(negedge clk);
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b1; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("flushw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1; flush = 1'b0; bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("flushw_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("flushw_stall", {31'h0, stall}, 32'h0);

        // Flush in IDLE: neither a legal nor an illegal request does anything.
        @(posedge clk); #1; in_valid = 1'b1; in_op = OP_SW; in_addr = 32'h80; flush = 1'b1;
        @(negedge clk);
        chk("flushi_byteen", {28'h0, bus_if.bus_byteen}, 32'h0);
        @(posedge clk); #1; in_op = OP_SH; in_addr = 32'h1;
        @(negedge clk);
        chk("flushi_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("flushi_exc", {31'h0, exc_valid}, 32'h0);
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;

        // Stray ack in IDLE.
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_rsp", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1; bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_req", {31'h0, bus_if.bus_req}, 32'h0);

        // Reset in the middle of WAIT abandons the access.
        @(posedge clk); #1; in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h44;
        @(negedge clk);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("rstw_req_before", {31'h0, bus_if.bus_req}, 32'h1);
        #2; reset_n = 1'b0; #1;
        chk("rstw_req_async", {31'h0, bus_if.bus_req}, 32'h0);
        chk("rstw_stall_async", {31'h0, stall}, 32'h0);
        @(posedge clk); #1; reset_n = 1'b1; bus_if.bus_ack = 1'b1;
        @(negedge clk);
        chk("rstw_no_rsp", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1; bus_if.bus_ack = 1'b0;
        @(negedge clk);

`ifdef DM_ACCESS_TIMEOUT_EN
        // No ack: abort with AdEL in the fourth WAIT cycle.
        @(posedge clk); #1; in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h100;
        sb_q.push_back('{is_exc: 1'b1, val: 32'd4});
        @(negedge clk);
        @(posedge clk); #1; in_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (exc_valid) break;
            @(posedge clk); #1;
        end
        chk("tmo_wait_cycles", n, 4);
        chk("tmo_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("tmo_idle_req", {31'h0, bus_if.bus_req}, 32'h0);
`else
        // Without the timeout the controller waits as long as it takes.
        @(posedge clk); #1; in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h100;
        sb_q.push_back('{is_exc: 1'b0, val: 32'h0F0F_0F0F});
        @(negedge clk);
        @(posedge clk); #1; in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n += int'(stall && bus_if.bus_req);
            @(posedge clk); #1;
        end
        chk("notmo_stalled", n, 40);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("notmo_rsp", {31'h0, rsp_valid}, 32'h1);
        @(posedge clk); #1; bus_if.bus_ack = 1'b0;
        @(negedge clk);
`endif

        // Random accesses across the data memory, some misaligned.
        for (int k = 0; k < 12; k++) begin
            access(op_t'($urandom_range(0, 7)), 32'($urandom_range(0, 32'h2fff)),
                   $urandom, $urandom, $urandom_range(0, 3));
        end

        @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
